// File: rtl/write_back_stage_if.sv
// MEM -> WB instruction handshake bundle.
// Slave modport is the write-back stage; master is the MEM stage driving it.
`ifndef WB_LOAD
`define WB_LOAD   2'b00
`define WB_JAL    2'b01
`define WB_NORMAL 2'b10
`define WB_HICCUP 2'b11
`endif

interface write_back_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_type;
  logic [XLEN-1:0]       in_pc;
  logic [XLEN-1:0]       in_result;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [2:0]            in_funct3;
  logic [1:0]            in_addr_lo;

  modport master (
    output in_valid,
    output in_type,
    output in_pc,
    output in_result,
    output in_rd,
    output in_funct3,
    output in_addr_lo,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_type,
    input  in_pc,
    input  in_result,
    input  in_rd,
    input  in_funct3,
    input  in_addr_lo,
    output in_ready
  );
endinterface

// File: rtl/write_back_stage.sv
// Write-back stage: waits for late loads, aligns them, drives the RF port.
// Optional WB_BYPASS_EN adds early-forwarding outputs of the pending commit.
`ifndef WB_LOAD
`define WB_LOAD   2'b00
`define WB_JAL    2'b01
`define WB_NORMAL 2'b10
`define WB_HICCUP 2'b11
`endif

module write_back_stage #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int LINK_OFFSET = 4,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  write_back_stage_if.slave     in_if,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rsp_data,
  input  logic                  flush,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  misalign_err,
  output logic [CNT_W-1:0]      retire_count
`ifdef WB_BYPASS_EN
  ,
  output logic                  bypass_valid,
  output logic [REG_ADDR_W-1:0] bypass_rd,
  output logic [XLEN-1:0]       bypass_data
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                state;
  logic [1:0]            h_type;
  logic [XLEN-1:0]       h_pc;
  logic [XLEN-1:0]       h_result;
  logic [REG_ADDR_W-1:0] h_rd;
  logic [2:0]            h_funct3;
  logic [1:0]            h_addr_lo;

  logic                  waiting;
  logic [1:0]            c_type;
  logic [XLEN-1:0]       c_pc;
  logic [XLEN-1:0]       c_result;
  logic [REG_ADDR_W-1:0] c_rd;
  logic [2:0]            c_funct3;
  logic [1:0]            c_addr_lo;

  logic                  is_load;
  logic                  is_hiccup;
  logic                  accept;
  logic                  park;
  logic                  commit;

  logic [XLEN-1:0]       shifted;
  logic [XLEN-1:0]       load_val;
  logic                  misal;
  logic [XLEN-1:0]       val;

  logic                  n_we;
  logic [REG_ADDR_W-1:0] n_waddr;
  logic [XLEN-1:0]       n_wdata;
  logic                  n_mis;
  logic                  n_retire;

  assign waiting        = (state == S_WAIT);
  assign in_if.in_ready = ~waiting;

  // In S_WAIT the commit is built from the parked copy, not the live bus.
  assign c_type    = waiting ? h_type    : in_if.in_type;
  assign c_pc      = waiting ? h_pc      : in_if.in_pc;
  assign c_result  = waiting ? h_result  : in_if.in_result;
  assign c_rd      = waiting ? h_rd      : in_if.in_rd;
  assign c_funct3  = waiting ? h_funct3  : in_if.in_funct3;
  assign c_addr_lo = waiting ? h_addr_lo : in_if.in_addr_lo;

  assign is_load   = (c_type == `WB_LOAD);
  assign is_hiccup = (c_type == `WB_HICCUP);

  assign accept = ~waiting & in_if.in_valid & ~flush;
  assign park   = accept & is_load & ~mem_rsp_valid;

  always_comb begin
    commit = 1'b0;
    if (!flush) begin
      if (waiting) commit = mem_rsp_valid;
      else commit = in_if.in_valid & (~is_load | mem_rsp_valid);
    end
  end

  assign shifted = mem_rsp_data >> {c_addr_lo, 3'b000};

  always_comb begin
    load_val = '0;
    misal    = 1'b0;
    unique case (1'b1)
      (c_funct3 == 3'b000): begin
        load_val = XLEN'($signed(shifted[7:0]));
      end
      (c_funct3 == 3'b001): begin
        load_val = XLEN'($signed(shifted[15:0]));
        misal    = (c_addr_lo == 2'b11);
      end
      (c_funct3 == 3'b100): begin
        load_val = XLEN'(shifted[7:0]);
      end
      (c_funct3 == 3'b101): begin
        load_val = XLEN'(shifted[15:0]);
        misal    = (c_addr_lo == 2'b11);
      end
      default: begin
        load_val = XLEN'($signed(shifted[31:0]));
        misal    = (c_addr_lo != 2'b00);
      end
    endcase
  end

  always_comb begin
    val = c_result;
    unique case (c_type)
      `WB_LOAD: val = load_val;
      `WB_JAL:  val = c_pc + XLEN'(LINK_OFFSET);
      default:  val = c_result;
    endcase
  end

  always_comb begin
    n_retire = commit & ~is_hiccup;
    n_mis    = commit & is_load & misal;
    n_we     = n_retire & ~n_mis & (c_rd != '0);
    n_waddr  = n_retire ? c_rd : '0;
    n_wdata  = n_we ? val : '0;
  end

`ifdef WB_BYPASS_EN
  assign bypass_valid = n_we;
  assign bypass_rd    = n_waddr;
  assign bypass_data  = n_wdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      h_type       <= '0;
      h_pc         <= '0;
      h_result     <= '0;
      h_rd         <= '0;
      h_funct3     <= '0;
      h_addr_lo    <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      misalign_err <= 1'b0;
      retire_count <= '0;
    end else begin
      rf_we        <= n_we;
      rf_waddr     <= n_waddr;
      rf_wdata     <= n_wdata;
      misalign_err <= n_mis;
      if (n_retire) retire_count <= retire_count + CNT_W'(1);
      unique case (state)
        S_IDLE: begin
          if (park) begin
            state     <= S_WAIT;
            h_type    <= in_if.in_type;
            h_pc      <= in_if.in_pc;
            h_result  <= in_if.in_result;
            h_rd      <= in_if.in_rd;
            h_funct3  <= in_if.in_funct3;
            h_addr_lo <= in_if.in_addr_lo;
          end
        end
        S_WAIT: begin
          if (flush || mem_rsp_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_back_stage.sv
// Directed plus randomized bench for write_back_stage.
// Expected results come from a byte-lane reference model of the load rules.
`ifndef WB_LOAD
`define WB_LOAD   2'b00
`define WB_JAL    2'b01
`define WB_NORMAL 2'b10
`define WB_HICCUP 2'b11
`endif

module tb_write_back_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int CW   = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            flush;
  logic            rf_we;
  logic [RW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            misalign_err;
  logic [CW-1:0]   retire_count;
`ifdef WB_BYPASS_EN
  logic            bypass_valid;
  logic [RW-1:0]   bypass_rd;
  logic [XLEN-1:0] bypass_data;
`endif

  write_back_stage_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();

  write_back_stage #(
    .XLEN(XLEN), .REG_ADDR_W(RW), .LINK_OFFSET(4), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_if(bus.slave),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .flush(flush),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .misalign_err(misalign_err),
    .retire_count(retire_count)
`ifdef WB_BYPASS_EN
    ,
    .bypass_valid(bypass_valid),
    .bypass_rd(bypass_rd),
    .bypass_data(bypass_data)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int unsigned exp_count = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.in_valid  = 1'b0;
    mem_rsp_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic drive(input logic [1:0] t, input logic [31:0] pc,
                       input logic [31:0] res, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [1:0] a);
    bus.in_valid   = 1'b1;
    bus.in_type    = t;
    bus.in_pc      = pc;
    bus.in_result  = res;
    bus.in_rd      = rd;
    bus.in_funct3  = f3;
    bus.in_addr_lo = a;
  endtask

  // Reference: byte-lane view of the load word, size from funct3.
  task automatic model(input logic [1:0] t, input logic [31:0] pc,
                       input logic [31:0] res, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [1:0] a,
                       input logic [31:0] word,
                       output logic we, output logic [4:0] wa,
                       output logic [31:0] wd, output logic mis,
                       output logic retire);
    logic [31:0] v;
    logic [31:0] mask;
    int size;
    v = 0;
    mis = 0;
    if (t == `WB_HICCUP) begin
      we = 0; wa = 0; wd = 0; retire = 0;
      return;
    end
    retire = 1;
    if (t == `WB_JAL) v = pc + 32'd4;
    else if (t == `WB_NORMAL) v = res;
    else begin
      if (f3 == 0 || f3 == 4) size = 1;
      else if (f3 == 1 || f3 == 5) size = 2;
      else size = 4;
      mis = (int'(a) + size) > 4;
      v = word / (32'd1 << (8 * a));
      if (size < 4) begin
        mask = (32'd1 << (8 * size)) - 1;
        v = v & mask;
        if ((f3 == 0 || f3 == 1) && v >= (mask + 1) / 2) v = v | ~mask;
      end
    end
    we = !mis && rd != 0;
    wa = rd;
    wd = we ? v : 32'd0;
  endtask

  // One instruction: optional response delay, then compare the commit.
  task automatic do_op(input string tag, input logic [1:0] t,
                       input logic [31:0] pc, input logic [31:0] res,
                       input logic [4:0] rd, input logic [2:0] f3,
                       input logic [1:0] a, input logic [31:0] word,
                       input int delay);
    logic we, mis, ret;
    logic [4:0] wa;
    logic [31:0] wd;
    model(t, pc, res, rd, f3, a, word, we, wa, wd, mis, ret);
    drive(t, pc, res, rd, f3, a);
    flush = 1'b0;
    if (t == `WB_LOAD && delay > 0) begin
      mem_rsp_valid = 1'b0;
      tick();
      drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      for (int k = 1; k < delay; k++) begin
        chk({tag, ".wait_ready"}, bus.in_ready, 0);
        chk({tag, ".wait_we"}, rf_we, 0);
        tick();
      end
      chk({tag, ".wait_ready"}, bus.in_ready, 0);
    end else begin
      chk({tag, ".ready"}, bus.in_ready, 1);
    end
    mem_rsp_valid = (t == `WB_LOAD) ? 1'b1 : 1'($urandom);
    mem_rsp_data  = word;
`ifdef WB_BYPASS_EN
    #1;
    chk({tag, ".byp_valid"}, bypass_valid, we);
    if (we) chk({tag, ".byp_data"}, bypass_data, wd);
`endif
    tick();
    quiet();
    if (ret) exp_count++;
    chk({tag, ".we"}, rf_we, we);
    chk({tag, ".waddr"}, rf_waddr, wa);
    chk({tag, ".wdata"}, rf_wdata, wd);
    chk({tag, ".mis"}, misalign_err, mis);
    chk({tag, ".count"}, retire_count, exp_count);
    chk({tag, ".ready_after"}, bus.in_ready, 1);
  endtask

  task automatic gap(input string tag);
    quiet();
    tick();
    chk({tag, ".gap_we"}, rf_we, 0);
    chk({tag, ".gap_mis"}, misalign_err, 0);
  endtask

  initial begin
    logic [1:0] t;
    logic [2:0] f3;
    quiet();
    drive(`WB_NORMAL, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    mem_rsp_data = 0;
    #12;
    chk("rst.we", rf_we, 0);
    chk("rst.waddr", rf_waddr, 0);
    chk("rst.wdata", rf_wdata, 0);
    chk("rst.mis", misalign_err, 0);
    chk("rst.count", retire_count, 0);
    chk("rst.ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_op("normal", `WB_NORMAL, 0, 32'hDEADBEEF, 5, 0, 0, 0, 0);
    chk("normal.lit", rf_wdata, 32'hDEADBEEF);
    chk("normal.cnt1", retire_count, 1);
    gap("normal");
    do_op("jal_wrap", `WB_JAL, 32'hFFFFFFFC, 0, 1, 0, 0, 0, 0);
    chk("jal_wrap.lit", rf_wdata, 0);
    do_op("hiccup", `WB_HICCUP, 0, 32'h1234, 7, 0, 0, 0, 0);
    gap("hiccup");
    do_op("lb", `WB_LOAD, 0, 0, 2, 3'b000, 2, 32'h12F45678, 0);
    chk("lb.lit", rf_wdata, 32'hFFFFFFF4);
    do_op("lbu", `WB_LOAD, 0, 0, 2, 3'b100, 2, 32'h12F45678, 0);
    chk("lbu.lit", rf_wdata, 32'h000000F4);
    do_op("lhu", `WB_LOAD, 0, 0, 2, 3'b101, 2, 32'h12F45678, 0);
    chk("lhu.lit", rf_wdata, 32'h000012F4);
    gap("lhu");
    do_op("lw_late", `WB_LOAD, 0, 0, 3, 3'b010, 0, 32'hCAFEF00D, 3);
    chk("lw_late.lit", rf_wdata, 32'hCAFEF00D);
    gap("lw_late");

    drive(`WB_LOAD, 0, 0, 6, 3'b010, 0);
    tick();
    quiet();
    chk("flush_wait.ready", bus.in_ready, 0);
    flush = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'h55AA55AA;
    tick();
    quiet();
    chk("flush_wait.we", rf_we, 0);
    chk("flush_wait.ready", bus.in_ready, 1);
    chk("flush_wait.count", retire_count, exp_count);

    drive(`WB_NORMAL, 0, 32'h77, 4, 0, 0);
    flush = 1'b1;
    tick();
    quiet();
    chk("flush_idle.we", rf_we, 0);
    chk("flush_idle.count", retire_count, exp_count);

    mem_rsp_valid = 1'b1;
    tick();
    quiet();
    chk("stray_rsp.we", rf_we, 0);

    do_op("lh_mis", `WB_LOAD, 0, 0, 8, 3'b001, 3, 32'h11223344, 0);
    gap("lh_mis");
    do_op("funct3_unk", `WB_LOAD, 0, 0, 9, 3'b111, 0, 32'h80000001, 1);

    drive(`WB_LOAD, 0, 0, 10, 3'b010, 0);
    tick();
    quiet();
    #2;
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    chk("rst_wait.we", rf_we, 0);
    chk("rst_wait.wdata", rf_wdata, 0);
    chk("rst_wait.count", retire_count, 0);
    chk("rst_wait.ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_rsp_valid = 1'b1;
    tick();
    quiet();
    chk("rst_wait.no_write", rf_we, 0);

    for (int i = 0; i < 300; i++) begin
      t  = 2'($urandom_range(0, 3));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        drive(t, $urandom, $urandom, 5'($urandom), f3, 2'($urandom));
        if (t == `WB_LOAD && $urandom_range(0, 1) == 1) begin
          tick();
          quiet();
        end
        flush = 1'b1;
        mem_rsp_valid = 1'($urandom);
        tick();
        quiet();
        chk("rnd_flush.we", rf_we, 0);
        chk("rnd_flush.count", retire_count, exp_count);
        chk("rnd_flush.ready", bus.in_ready, 1);
      end else begin
        do_op("rnd", t, $urandom, $urandom, 5'($urandom), f3,
              2'($urandom), $urandom,
              (t == `WB_LOAD) ? $urandom_range(0, 3) : 0);
        if ($urandom_range(0, 3) == 0) gap("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
